// File: rtl/vga_sync_receiver.sv
// VGA raster sink: rebuilds active-pixel coordinates from hs/vs/blank and checks the timing, locking after one clean frame.
// Inputs are sampled on pix_ce_i only; pixel outputs and frame_start are registered 1 clk after the strobe; there is no backpressure.
module vga_sync_receiver #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pix_ce_i,
  input  logic       hs_n_i,
  input  logic       vs_n_i,
  input  logic       blank_n_i,
  output logic       pix_valid_o,
  output logic [9:0] rx_x_o,
  output logic [9:0] rx_y_o,
  output logic       frame_start_o,
  output logic       locked_o,
  output logic [7:0] err_count_o
);
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_e;

  state_e      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d, first_q, first_d;
  logic [9:0]  hcnt_q, hcnt_d, acnt_q, acnt_d, vcnt_q, vcnt_d, ycnt_q, ycnt_d;
  logic [9:0]  rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic [7:0]  err_q, err_d;
  logic        hs_fall, hs_rise, vs_fall, vs_rise, err;
  logic [10:0] hcnt_p1;

  function automatic logic [9:0] inc_sat(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign hs_fall = pix_ce_i & hs_q & ~hs_n_i;
  assign hs_rise = pix_ce_i & ~hs_q & hs_n_i;
  assign vs_fall = pix_ce_i & vs_q & ~vs_n_i;
  assign vs_rise = pix_ce_i & ~vs_q & vs_n_i;
  assign hcnt_p1 = {1'b0, hcnt_q} + 11'd1;

  // first_q masks the line-length check until a full line has been seen since SEARCH.
  always_comb begin
    err = 1'b0;
    if (hs_fall && !first_q && hcnt_p1 != 11'(H_TOTAL)) err = 1'b1;
    if (hs_rise && hcnt_p1 != 11'(H_SYNC)) err = 1'b1;
    if (hs_fall && acnt_q != 10'd0 && acnt_q != 10'(H_ACTIVE)) err = 1'b1;
    if (vs_fall && state_q != SEARCH &&
        (vcnt_q != 10'(V_TOTAL) || ycnt_q != 10'(V_ACTIVE))) err = 1'b1;
    if (vs_rise && vcnt_q != 10'(V_SYNC)) err = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    first_d       = first_q;
    hcnt_d        = hcnt_q;
    acnt_d        = acnt_q;
    vcnt_d        = vcnt_q;
    ycnt_d        = ycnt_q;
    rx_x_d        = rx_x_q;
    rx_y_d        = rx_y_q;
    pix_valid_d   = 1'b0;
    frame_start_d = vs_fall;
    err_d         = err_q;
    if (pix_ce_i) begin
      hs_d        = hs_n_i;
      vs_d        = vs_n_i;
      pix_valid_d = blank_n_i & (state_q == LOCKED);
      if (pix_valid_d) begin
        rx_x_d = acnt_q;
        rx_y_d = ycnt_q;
      end
      // A coincident VS fall starts the new frame before this HS fall is counted.
      if (vs_fall) begin
        vcnt_d = '0;
        ycnt_d = '0;
      end
      if (hs_fall) begin
        hcnt_d  = '0;
        acnt_d  = '0;
        first_d = 1'b0;
        vcnt_d  = inc_sat(vcnt_d);
        if (acnt_q == 10'(H_ACTIVE)) ycnt_d = inc_sat(ycnt_d);
      end else begin
        hcnt_d = inc_sat(hcnt_q);
        if (blank_n_i) acnt_d = inc_sat(acnt_q);
      end
    end
    case (state_q)
      SEARCH:  if (vs_fall) state_d = CHECK;
      CHECK:   if (err) state_d = SEARCH; else if (vs_fall) state_d = LOCKED;
      LOCKED:  if (err) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
    if (err && state_q != SEARCH) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      hcnt_d  = '0;
      acnt_d  = '0;
      vcnt_d  = '0;
      ycnt_d  = '0;
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      first_q       <= 1'b1;
      hcnt_q        <= '0;
      acnt_q        <= '0;
      vcnt_q        <= '0;
      ycnt_q        <= '0;
      rx_x_q        <= '0;
      rx_y_q        <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      first_q       <= first_d;
      hcnt_q        <= hcnt_d;
      acnt_q        <= acnt_d;
      vcnt_q        <= vcnt_d;
      ycnt_q        <= ycnt_d;
      rx_x_q        <= rx_x_d;
      rx_y_q        <= rx_y_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign pix_valid_o   = pix_valid_q;
  assign rx_x_o        = rx_x_q;
  assign rx_y_o        = rx_y_q;
  assign frame_start_o = frame_start_q;
  assign locked_o      = (state_q == LOCKED);
  assign err_count_o   = err_q;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down raster: event-level reference model compared every cycle,
// plus frame-level literal expectations for lock, coordinates, error counting and reset.
module tb_vga_sync_receiver;
  localparam int HT = 40, HS = 6, HA = 24, VT = 20, VS = 2, VA = 12;
  localparam int S_SEARCH = 0, S_CHECK = 1, S_LOCKED = 2;

  logic       clk = 1'b0, rst_n = 1'b0, pix_ce = 1'b0;
  logic       hs_n = 1'b1, vs_n = 1'b1, blank_n = 1'b0;
  logic       pix_valid, frame_start, locked;
  logic [9:0] rx_x, rx_y;
  logic [7:0] err_count;

  always #10 clk = ~clk;

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE(HA), .V_TOTAL(VT), .V_SYNC(VS), .V_ACTIVE(VA)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pix_ce_i(pix_ce), .hs_n_i(hs_n), .vs_n_i(vs_n),
    .blank_n_i(blank_n), .pix_valid_o(pix_valid), .rx_x_o(rx_x), .rx_y_o(rx_y),
    .frame_start_o(frame_start), .locked_o(locked), .err_count_o(err_count)
  );

  int checks = 0, errors = 0;
  // reference model state: raster counters as plain integers
  int m_state, m_h, m_a, m_v, m_y, m_err, e_x, e_y;
  bit m_hp, m_vp, m_first, e_pv, e_fs;
  // frame-level statistics taken from the DUT outputs
  int pv_tot = 0, fs_tot = 0, first_x = -1, first_y = -1, last_x = -1, last_y = -1;
  bit armed = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_state = S_SEARCH; m_h = 0; m_a = 0; m_v = 0; m_y = 0; m_err = 0;
    m_hp = 1'b1; m_vp = 1'b1; m_first = 1'b1; e_pv = 1'b0; e_fs = 1'b0; e_x = 0; e_y = 0;
  endtask

  task automatic model_step(bit ce, bit h, bit v, bit b);
    bit hf, hr, vf, vr, bad;
    e_pv = 1'b0; e_fs = 1'b0;
    if (!ce) return;
    hf = m_hp && !h; hr = !m_hp && h; vf = m_vp && !v; vr = !m_vp && v;
    m_hp = h; m_vp = v;
    bad = 1'b0;
    if (hf && !m_first && m_h + 1 != HT) bad = 1'b1;
    if (hr && m_h + 1 != HS) bad = 1'b1;
    if (hf && m_a != 0 && m_a != HA) bad = 1'b1;
    if (vf && m_state != S_SEARCH && (m_v != VT || m_y != VA)) bad = 1'b1;
    if (vr && m_v != VS) bad = 1'b1;
    e_fs = vf;
    e_pv = b && (m_state == S_LOCKED);
    if (e_pv) begin e_x = m_a; e_y = m_y; end
    if (vf) begin m_v = 0; m_y = 0; end
    if (hf) begin
      if (m_a == HA) m_y = sat(m_y + 1, 1023);
      m_v = sat(m_v + 1, 1023); m_h = 0; m_a = 0; m_first = 1'b0;
    end else begin
      m_h = sat(m_h + 1, 1023);
      if (b) m_a = sat(m_a + 1, 1023);
    end
    if (m_state == S_SEARCH) begin
      if (vf) m_state = S_CHECK;
    end else if (bad) begin
      m_err = sat(m_err + 1, 255); m_state = S_SEARCH;
      m_h = 0; m_a = 0; m_v = 0; m_y = 0; m_first = 1'b1;
    end else if (vf && m_state == S_CHECK) begin
      m_state = S_LOCKED;
    end
  endtask

  task automatic compare();
    if (!rst_n) begin
      chk("reset_pix_valid", int'(pix_valid), 0);
      chk("reset_rx_x", int'(rx_x), 0);
      chk("reset_rx_y", int'(rx_y), 0);
      chk("reset_frame_start", int'(frame_start), 0);
      chk("reset_locked", int'(locked), 0);
      chk("reset_err_count", int'(err_count), 0);
    end else begin
      chk("pix_valid", int'(pix_valid), int'(e_pv));
      chk("frame_start", int'(frame_start), int'(e_fs));
      chk("locked", int'(locked), int'(m_state == S_LOCKED));
      chk("err_count", int'(err_count), m_err);
      if (e_pv) begin
        chk("rx_x", int'(rx_x), e_x);
        chk("rx_y", int'(rx_y), e_y);
      end
    end
    if (frame_start) begin fs_tot++; armed = 1'b1; end
    if (pix_valid) begin
      pv_tot++; last_x = int'(rx_x); last_y = int'(rx_y);
      if (armed) begin first_x = int'(rx_x); first_y = int'(rx_y); armed = 1'b0; end
    end
  endtask

  // One clk: drive inputs at the falling edge, step the model at the rising edge, compare at the next falling edge.
  task automatic cycle(bit ce, bit h, bit v, bit b);
    pix_ce = ce; hs_n = h; vs_n = v; blank_n = b;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step(ce, h, v, b);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic strobe(bit h, bit v, bit b);
    int gap;
    gap = int'($urandom_range(0, 2));
    for (int i = 0; i < gap; i++) idle();
    cycle(1'b1, h, v, b);
  endtask

  task automatic reset_pulse(int clks);
    rst_n = 1'b0;
    #1;
    chk("reset_async_locked", int'(locked), 0);
    chk("reset_async_err_count", int'(err_count), 0);
    for (int i = 0; i < clks; i++) idle();
    rst_n = 1'b1;
  endtask

  // Standard scaled raster; optional faults: a long line, a short sync, a strobe stall, a mid-frame reset.
  task automatic send_frame(int lines, int long_line, int short_line, int stall_line, int rst_line);
    for (int l = 0; l < lines; l++) begin
      for (int s = 0; s < HT + ((l == long_line) ? 1 : 0); s++) begin
        if (l == stall_line && s == 20) for (int i = 0; i < 1000; i++) idle();
        if (l == rst_line && s == 15) reset_pulse(3);
        strobe(s >= ((l == short_line) ? HS - 1 : HS), l >= VS,
               l >= 4 && l < 4 + VA && s >= 10 && s < 10 + HA);
      end
    end
  endtask

  task automatic clean_frame();
    send_frame(VT, -1, -1, -1, -1);
  endtask

  initial begin
    int p0, f0;
    bit rh, rv, rb;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) idle();
    rst_n = 1'b1;
    idle();

    clean_frame();
    chk("lock_after_first_vs_fall", int'(locked), 0);
    p0 = pv_tot;
    clean_frame();
    chk("lock_after_second_vs_fall", int'(locked), 1);
    chk("ideal_pixel_count", pv_tot - p0, HA * VA);
    chk("ideal_first_x", first_x, 0);
    chk("ideal_first_y", first_y, 0);
    chk("ideal_last_x", last_x, HA - 1);
    chk("ideal_last_y", last_y, VA - 1);
    chk("ideal_err_count", int'(err_count), 0);

    p0 = pv_tot;
    send_frame(VT, 7, -1, -1, -1);
    chk("long_line_err_count", int'(err_count), 1);
    chk("long_line_unlocked", int'(locked), 0);
    chk("long_line_pixels_before_error", pv_tot - p0, 4 * HA);
    clean_frame();
    chk("long_line_relock_one_frame", int'(locked), 0);
    p0 = pv_tot;
    clean_frame();
    chk("long_line_relocked", int'(locked), 1);
    chk("long_line_relock_pixels", pv_tot - p0, HA * VA);

    p0 = pv_tot;
    send_frame(VT, -1, 9, -1, -1);
    chk("short_sync_err_count", int'(err_count), 2);
    chk("short_sync_unlocked", int'(locked), 0);
    chk("short_sync_pixels_before_error", pv_tot - p0, 5 * HA);
    clean_frame();
    clean_frame();
    chk("short_sync_relocked", int'(locked), 1);

    send_frame(VT + 1, -1, -1, -1, -1);
    chk("long_frame_no_error_yet", int'(err_count), 2);
    p0 = pv_tot;
    clean_frame();
    chk("long_frame_err_count", int'(err_count), 3);
    chk("long_frame_unlocked", int'(locked), 0);
    chk("long_frame_no_pixels", pv_tot - p0, 0);
    clean_frame();
    chk("long_frame_check_state", int'(locked), 0);
    clean_frame();
    chk("long_frame_relocked", int'(locked), 1);

    p0 = pv_tot;
    send_frame(VT, -1, -1, 6, -1);
    chk("stall_pixel_count", pv_tot - p0, HA * VA);
    chk("stall_err_count", int'(err_count), 3);
    chk("stall_locked", int'(locked), 1);

    send_frame(VT, -1, -1, -1, 8);
    chk("mid_reset_err_count", int'(err_count), 0);
    f0 = fs_tot;
    clean_frame();
    chk("mid_reset_frame_start_pulse", fs_tot - f0, 1);
    chk("mid_reset_one_vs_fall", int'(locked), 0);
    clean_frame();
    chk("mid_reset_relocked", int'(locked), 1);

    rh = 1'b1; rv = 1'b1; rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rh = ~rh;
      if ($urandom_range(0, 39) == 0) rv = ~rv;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      strobe(rh, rv, rb);
    end

    reset_pulse(2);
    for (int i = 1; i <= 300; i++) begin
      strobe(1'b1, 1'b1, 1'b0);
      strobe(1'b1, 1'b0, 1'b0);
      strobe(1'b0, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 1'b0);
      if (i == 254) chk("err_count_254", int'(err_count), 254);
    end
    chk("err_count_saturated", int'(err_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
